// File: rtl/prog_loader_if.sv
// ----------------------------------------------------------------------------
// prog_loader_if: byte-stream handshake feeding the program loader.
//   in_data  : received byte (master -> slave)
//   in_valid : in_data valid this cycle (master -> slave)
//   in_ready : slave accepts the byte; transfer on in_valid && in_ready
// ----------------------------------------------------------------------------
interface prog_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/prog_loader.sv
// ----------------------------------------------------------------------------
// prog_loader: byte-stream program loader for the CPU instruction memory.
// Receives frames  SYNC_BYTE, CNT_HI, CNT_LO, CNT x {hi, lo} [, checksum],
// assembles big-endian 16-bit words and writes them to imem from address 0.
// The CPU is held while a frame is in flight and released with a one-cycle
// cpu_start pulse when the frame completes successfully.
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN
//   defined   : a trailing checksum byte (XOR of all data bytes) is checked.
//   undefined : no checksum byte; the frame ends after the last data word.
//
// Ports:
//   CLK_50       in   system clock
//   RST          in   synchronous active-high reset
//   in_if        slave byte stream (in_data / in_valid / in_ready)
//   imem_we      out  instruction memory write strobe
//   imem_addr    out  write address
//   imem_wdata   out  write data
//   cpu_hold     out  CPU halted while high
//   cpu_start    out  one-cycle pulse after a successful load
//   load_err     out  sticky error flag, cleared by SYNC_BYTE or RST
//   words_loaded out  words written in the current or last frame
// ----------------------------------------------------------------------------
module prog_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              CLK_50,
    input  logic              RST,
    prog_loader_if.slave      in_if,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [16:0] MaxCount = 17'd1 << ADDR_W;

    typedef enum logic [2:0] {
        StIdle,
        StCntHi,
        StCntLo,
        StDataHi,
        StDataLo,
        StFinish,
        StErr
`ifdef PROG_LOADER_CHECKSUM_EN
        , StChk
`endif
    } state_e;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_e StAfterData = StChk;
`else
    localparam state_e StAfterData = StFinish;
`endif

    state_e            r_state,  w_state_d;
    logic [7:0]        r_cnt_hi, w_cnt_hi_d;
    logic [ADDR_W:0]   r_count,  w_count_d;
    logic [7:0]        r_hi,     w_hi_d;
    logic [ADDR_W:0]   r_rcvd,   w_rcvd_d;
    logic              r_ready;
    logic              r_we,     w_we_d;
    logic [ADDR_W-1:0] r_addr,   w_addr_d;
    logic [15:0]       r_wdata,  w_wdata_d;
    logic              r_hold,   w_hold_d;
    logic              r_start,  w_start_d;
    logic              r_err,    w_err_d;
    logic [ADDR_W:0]   r_words,  w_words_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        r_chk,    w_chk_d;
`endif

    logic              w_fire;
    logic [16:0]       w_cnt_full;
    logic [ADDR_W:0]   w_rcvd_inc;

    assign w_fire     = in_if.in_valid && r_ready;
    assign w_cnt_full = {1'b0, r_cnt_hi, in_if.in_data};
    assign w_rcvd_inc = r_rcvd + (ADDR_W + 1)'(1);

    always_comb begin
        w_state_d  = r_state;
        w_cnt_hi_d = r_cnt_hi;
        w_count_d  = r_count;
        w_hi_d     = r_hi;
        w_rcvd_d   = r_rcvd;
        w_we_d     = 1'b0;
        w_addr_d   = r_addr;
        w_wdata_d  = r_wdata;
        w_hold_d   = r_hold;
        w_start_d  = 1'b0;
        w_err_d    = r_err;
        w_words_d  = r_words;
`ifdef PROG_LOADER_CHECKSUM_EN
        w_chk_d    = r_chk;
`endif

        unique case (r_state)
            // ERR behaves like IDLE except that load_err and cpu_hold stay set.
            StIdle, StErr: begin
                if (w_fire && in_if.in_data == SYNC_BYTE) begin
                    w_state_d = StCntHi;
                    w_hold_d  = 1'b1;
                    w_err_d   = 1'b0;
                    w_words_d = '0;
                    w_rcvd_d  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    w_chk_d   = '0;
`endif
                end
            end
            StCntHi: begin
                if (w_fire) begin
                    w_cnt_hi_d = in_if.in_data;
                    w_state_d  = StCntLo;
                end
            end
            StCntLo: begin
                if (w_fire) begin
                    if (w_cnt_full > MaxCount) begin
                        w_state_d = StErr;
                        w_err_d   = 1'b1;
                    end else begin
                        w_count_d = w_cnt_full[ADDR_W:0];
                        w_state_d = (w_cnt_full == '0) ? StAfterData : StDataHi;
                    end
                end
            end
            StDataHi: begin
                if (w_fire) begin
                    w_hi_d    = in_if.in_data;
                    w_state_d = StDataLo;
`ifdef PROG_LOADER_CHECKSUM_EN
                    w_chk_d   = r_chk ^ in_if.in_data;
`endif
                end
            end
            StDataLo: begin
                if (w_fire) begin
                    // Write lands the cycle after the low-byte handshake.
                    w_we_d    = 1'b1;
                    w_addr_d  = r_rcvd[ADDR_W-1:0];
                    w_wdata_d = {r_hi, in_if.in_data};
                    w_rcvd_d  = w_rcvd_inc;
                    w_words_d = w_rcvd_inc;
                    w_state_d = (w_rcvd_inc == r_count) ? StAfterData : StDataHi;
`ifdef PROG_LOADER_CHECKSUM_EN
                    w_chk_d   = r_chk ^ in_if.in_data;
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            StChk: begin
                if (w_fire) begin
                    if (in_if.in_data == r_chk) begin
                        w_state_d = StFinish;
                    end else begin
                        w_state_d = StErr;
                        w_err_d   = 1'b1;
                    end
                end
            end
`endif
            // Pulse is issued one cycle after entry so it never overlaps the
            // final imem write.
            StFinish: begin
                w_hold_d  = 1'b0;
                w_start_d = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK_50) begin
        if (RST) begin
            r_state  <= StIdle;
            r_cnt_hi <= '0;
            r_count  <= '0;
            r_hi     <= '0;
            r_rcvd   <= '0;
            r_ready  <= 1'b1;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_hold   <= 1'b0;
            r_start  <= 1'b0;
            r_err    <= 1'b0;
            r_words  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_chk    <= '0;
`endif
        end else begin
            r_state  <= w_state_d;
            r_cnt_hi <= w_cnt_hi_d;
            r_count  <= w_count_d;
            r_hi     <= w_hi_d;
            r_rcvd   <= w_rcvd_d;
            r_ready  <= 1'b1;
            r_we     <= w_we_d;
            r_addr   <= w_addr_d;
            r_wdata  <= w_wdata_d;
            r_hold   <= w_hold_d;
            r_start  <= w_start_d;
            r_err    <= w_err_d;
            r_words  <= w_words_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_chk    <= w_chk_d;
`endif
        end
    end

    assign in_if.in_ready = r_ready;
    assign imem_we        = r_we;
    assign imem_addr      = r_addr;
    assign imem_wdata     = r_wdata;
    assign cpu_hold       = r_hold;
    assign cpu_start      = r_start;
    assign load_err       = r_err;
    assign words_loaded   = r_words;

endmodule
